// File: rtl/mips_cache_instr_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_cache_instr_ctrl_if
//
// Avalon-style read-only memory bus used by the instruction-cache fill engine.
//
// Signals:
//   mem_address     [31:0]  word-aligned byte address of the request
//   mem_read                read request, held until accepted
//   mem_byteenable  [3:0]   all lanes enabled while mem_read is high
//   mem_waitrequest         memory not ready; requester must hold the request
//   mem_readdata    [31:0]  read data, valid when mem_read && !mem_waitrequest
//
// Modports:
//   master  - the fill engine (drives the request, receives the data)
//   slave   - the memory (receives the request, drives wait/data)
// -----------------------------------------------------------------------------
interface mips_cache_instr_ctrl_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        output mem_address,
        output mem_read,
        output mem_byteenable,
        input  mem_waitrequest,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        input  mem_byteenable,
        output mem_waitrequest,
        output mem_readdata
    );
endinterface

// File: rtl/mips_cache_instr_ctrl.sv
// -----------------------------------------------------------------------------
// mips_cache_instr_ctrl
//
// Memory-side fill engine for the instruction cache. When the cache reports a
// miss (stall), the engine issues one Avalon read for the word-aligned fetch
// address, waits out mem_waitrequest, and hands the word back to the cache as
// a one-cycle data_valid pulse. If the CPU has moved on by the time memory
// accepts the request, the word is dropped silently.
//
// Parameters:
//   TIMEOUT_CYCLES  consecutive wait cycles in one transaction that set
//                   the sticky timeout_err flag
//   MISS_CNT_WIDTH  width of the saturating fill counter
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   addr         CPU fetch byte address (same value the cache sees)
//   stall        cache miss indication
//   data_out     fill word to the cache data_in (qualify with data_valid)
//   data_valid   one-cycle fill pulse
//   mem          memory bus (master side)
//   busy         high while a transaction is in flight (REQ or RESP)
//   timeout_err  sticky bus-timeout flag, cleared only by reset
//   miss_count   number of fills delivered, saturating
// -----------------------------------------------------------------------------
module mips_cache_instr_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MISS_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr,
    input  logic                      stall,
    output logic [31:0]               data_out,
    output logic                      data_valid,
    mips_cache_instr_ctrl_if.master   mem,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [MISS_CNT_WIDTH-1:0] miss_count
);

    // Wait counter is wide enough to hold TIMEOUT_CYCLES itself and parks
    // there, so a very long stall never wraps around.
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [MISS_CNT_WIDTH-1:0] MISS_MAX = '1;
    localparam logic [MISS_CNT_WIDTH-1:0] MISS_ONE = MISS_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [31:0]               req_addr_reg, req_addr_next;
    logic [31:0]               data_out_reg, data_out_next;
    logic [WAIT_W-1:0]         wait_cnt_reg, wait_cnt_next;
    logic                      timeout_reg, timeout_next;
    logic [MISS_CNT_WIDTH-1:0] miss_cnt_reg, miss_cnt_next;

    logic [31:0] fetch_word_addr;
    logic        unused_addr_bits;

    // The memory is word-addressed in byte units; the byte offset is dropped.
    assign fetch_word_addr  = {addr[31:2], 2'b00};
    assign unused_addr_bits = ^addr[1:0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            req_addr_reg <= '0;
            data_out_reg <= '0;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            miss_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            req_addr_reg <= req_addr_next;
            data_out_reg <= data_out_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
            miss_cnt_reg <= miss_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        req_addr_next = req_addr_reg;
        data_out_next = data_out_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        miss_cnt_next = miss_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (stall) begin
                    req_addr_next = fetch_word_addr;
                    state_next    = S_REQ;
                end
            end

            S_REQ: begin
                if (mem.mem_waitrequest) begin
                    // Request must be held; just account for the wait.
                    if (wait_cnt_reg != WAIT_LIMIT) begin
                        wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                    end
                    if (wait_cnt_reg >= WAIT_LAST) begin
                        timeout_next = 1'b1;
                    end
                end else begin
                    data_out_next = mem.mem_readdata;
                    wait_cnt_next = '0;
                    // Deliver only if the cache is still missing on the same
                    // word; otherwise the fetch was redirected and the word
                    // is stale.
                    if (stall && (fetch_word_addr == req_addr_reg)) begin
                        state_next = S_RESP;
                        // Bumped on the accept edge so the new count becomes
                        // visible together with the data_valid pulse.
                        if (miss_cnt_reg != MISS_MAX) begin
                            miss_cnt_next = miss_cnt_reg + MISS_ONE;
                        end
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_RESP: begin
                // The cache writes the word on this edge, so any stall seen
                // now is stale; always drop back to IDLE.
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (all decoded from registered state, so reset forces them low
    // without waiting for a clock edge)
    // -------------------------------------------------------------------------
    assign mem.mem_read       = (state_reg == S_REQ);
    assign mem.mem_address    = req_addr_reg;
    assign mem.mem_byteenable = (state_reg == S_REQ) ? 4'b1111 : 4'b0000;

    assign data_out    = data_out_reg;
    assign data_valid  = (state_reg == S_RESP);
    assign busy        = (state_reg != S_IDLE);
    assign timeout_err = timeout_reg;
    assign miss_count  = miss_cnt_reg;

endmodule

// File: doc/mips_cache_instr_ctrl.md
Name: mips_cache_instr_ctrl

Overview:
- Memory-side fill engine for the instruction cache: watches the cache's miss/stall output and fetches the missing word over the Avalon-style memory bus.
- Returns the word to the cache as a one-cycle data_valid pulse.
- Sits between the instruction cache's data_in/data_valid inputs and the shared memory bus.
- Also provides a sticky bus-timeout flag and a miss counter for debug and performance.

Parameters:
- TIMEOUT_CYCLES, 1024: count of consecutive mem_waitrequest cycles in one transaction that sets timeout_err.
- MISS_CNT_WIDTH, 32: width of miss_count.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- addr  input  32  CPU fetch byte address (same signal the cache sees)
- stall  input  1  cache miss indication, high while read_en and no hit
- data_out  output  32  fill word to cache data_in
- data_valid  output  1  fill word valid, one-cycle pulse
- mem_address  output  32  word-aligned memory byte address
- mem_read  output  1  Avalon read request
- mem_byteenable  output  4  always 4'b1111 while mem_read is high, else 4'b0000
- mem_waitrequest  input  1  memory not ready; hold request
- mem_readdata  input  32  read data, valid when mem_read && !mem_waitrequest
- busy  output  1  high in REQ or RESP
- timeout_err  output  1  sticky timeout flag
- miss_count  output  MISS_CNT_WIDTH  number of fills delivered, saturating

Behaviour:
- Reset (rst low, asynchronous) puts the block in IDLE.
  - All outputs read 0: data_out=0, data_valid=0, mem_address=0, mem_read=0, mem_byteenable=0, busy=0, timeout_err=0, miss_count=0.
  - The wait counter and the latched address also clear.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If stall=1 at a clock edge: latch req_addr={addr[31:2],2'b00}, drive mem_address=req_addr, mem_read=1, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_read, mem_address and mem_byteenable are held stable until accepted.
  - If mem_waitrequest=1: stay in REQ and increment the wait counter.
    - When the counter reaches TIMEOUT_CYCLES, set timeout_err=1. It stays set until reset.
    - The transaction is not abandoned; the Avalon protocol forbids dropping a request.
  - If mem_waitrequest=0 (accept): capture mem_readdata into data_out, deassert mem_read in the next cycle, clear the wait counter.
    - Go to RESP if stall=1 and {addr[31:2],2'b00}==req_addr in the accept cycle.
    - Otherwise (CPU redirected or miss withdrawn) discard the word and go to IDLE. data_valid is not pulsed and miss_count is not incremented.
- RESP:
  - data_valid=1 for exactly one cycle; data_out holds the word.
  - miss_count increments by 1, saturating at all-ones.
  - Return to IDLE unconditionally.
  - The cache writes the word on this edge, so stall is low next cycle. No re-request is issued from a stale stall.
- Latency: accept in cycle N gives data_valid in cycle N+1. Minimum miss-to-fill latency is 2 cycles after stall is first sampled (IDLE→REQ with immediate accept→RESP).
- Only one outstanding transaction at a time. stall is ignored while in REQ or RESP, except for the accept-cycle address check.
- data_out keeps its last value outside RESP. Consumers must qualify it with data_valid.
- Reset asserted mid-transaction aborts immediately to IDLE with mem_read=0. The memory side is assumed to be reset by the same signal.

Test Plan:
- Reset then single miss: stall=1, addr=0xBFC00004; memory waitrequest=0 immediately with readdata=0x24020005 → cycle 1 mem_read=1 with mem_address=0xBFC00004; cycle 2 data_valid=1 with data_out=0x24020005; miss_count=1; back in IDLE.
- Unaligned address plus waitrequest: addr=0x1003, waitrequest high for 3 cycles → mem_address=0x1000 held stable with mem_read=1 for 4 cycles; one data_valid pulse; busy high throughout.
- Redirect mid-request: addr changes from 0x2000 to 0x3000 while in REQ → 0x2000 word discarded with no data_valid and miss_count unchanged; new request to 0x3000 issued on the following cycle.
- Timeout: TIMEOUT_CYCLES=8, waitrequest held high for 10 cycles → timeout_err rises after the 8th wait cycle and stays high after completion and after a later fill; it clears only on rst low.
- Async reset mid-REQ: rst low between clock edges → mem_read, busy, data_valid and miss_count are 0 immediately, before the next clk edge.
- Counter saturation: MISS_CNT_WIDTH=2, 5 back-to-back misses → miss_count reads 1, 2, 3, 3, 3.
